control_sequencer: RTL and testbench

- Hardwired control unit that drives the datapath's per-cycle control strobes (register out/in enables, bus source selects, ALU op select, memory read) from a fetched instruction.
- It is the hardware counterpart of the hand-sequenced T0..T4 control driving the datapath today, and replaces bench-driven strobes for instruction fetch and register-register ALU instructions.
- It sits beside the datapath, observes IR, and sources every control input the datapath takes for these instruction classes.

---
 rtl/cpu_ctrl_pkg.sv | 93 +++++++++
 rtl/reg_select_decoder.sv | 16 +
 rtl/control_sequencer.sv | 131 +++++++++++++
 tb/tb_control_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: IR field layout,
// opcodes, state encodings and ALU select bit positions.
package cpu_ctrl_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    localparam int ALU_W    = 13;
    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    // SHORT = two-operand, 32-bit result; LONG = mul/div, 64-bit result in HI/LO
    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_SHORT   = 2'd1,
        CLS_LONG    = 2'd2,
        CLS_UNARY   = 2'd3
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:  return CLS_SHORT;
            OP_MUL, OP_DIV:           return CLS_LONG;
            OP_NEG, OP_NOT:           return CLS_UNARY;
            default:                  return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] opc);
        logic [ALU_W-1:0] sel;
        sel = '0;
        case (opc)
            OP_ADD:  sel[ALU_ADD]  = 1'b1;
            OP_SUB:  sel[ALU_SUB]  = 1'b1;
            OP_AND:  sel[ALU_AND]  = 1'b1;
            OP_OR:   sel[ALU_OR]   = 1'b1;
            OP_ROR:  sel[ALU_ROR]  = 1'b1;
            OP_ROL:  sel[ALU_ROL]  = 1'b1;
            OP_SHR:  sel[ALU_SHR]  = 1'b1;
            OP_SHRA: sel[ALU_SHRA] = 1'b1;
            OP_SHL:  sel[ALU_SHL]  = 1'b1;
            OP_MUL:  sel[ALU_MUL]  = 1'b1;
            OP_DIV:  sel[ALU_DIV]  = 1'b1;
            OP_NEG:  sel[ALU_NEG]  = 1'b1;
            OP_NOT:  sel[ALU_NOT]  = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register field to one-hot register strobe, all zero when disabled.
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic                en,
    input  logic [3:0]          field,
    output logic [NUM_REGS-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign onehot[gi] = en && (field == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control unit: fetch plus register-register ALU instructions.
// Only the state is registered; every strobe is decoded from state and live IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int   NUM_REGS        = 16,
    parameter logic HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         IR,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [ALU_W-1:0]    alu_op,
    output logic                instr_done,
    output logic                halted,
    output logic [3:0]          state
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [3:0] after_done;

    logic [4:0] opcode;
    op_class_t  cls;
    logic       is_short, is_long, is_unary, is_illegal, is_two;
    logic       in_t3, in_t4, in_t5, in_t6;
    logic       alu_en, rout_en, rin_en;
    logic [3:0] rout_field;
    logic       unused_ir;

    assign opcode     = IR[OPC_MSB:OPC_LSB];
    assign cls        = op_class(opcode);
    assign is_short   = (cls == CLS_SHORT);
    assign is_long    = (cls == CLS_LONG);
    assign is_unary   = (cls == CLS_UNARY);
    assign is_illegal = (cls == CLS_ILLEGAL);
    assign is_two     = is_short || is_long;
    assign unused_ir  = ^IR[RC_LSB-1:0];

    assign in_t3 = (state_reg == ST_T3);
    assign in_t4 = (state_reg == ST_T4);
    assign in_t5 = (state_reg == ST_T5);
    assign in_t6 = (state_reg == ST_T6);

    assign after_done = run ? ST_T0 : ST_IDLE;

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE: state_next = run ? ST_T0 : ST_IDLE;
            ST_T0:   state_next = ST_T1;
            ST_T1:   state_next = mem_ready ? ST_T2 : ST_T1;
            ST_T2:   state_next = ST_T3;
            ST_T3: begin
                if (is_illegal)
                    state_next = HALT_ON_ILLEGAL ? ST_HALT : after_done;
                else
                    state_next = ST_T4;
            end
            ST_T4:   state_next = is_unary ? after_done : ST_T5;
            ST_T5:   state_next = is_long ? ST_T6 : after_done;
            ST_T6:   state_next = after_done;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Rb is the source in T3, Rc in T4 (second operand of two-operand ops)
    assign rout_en    = (in_t3 && (is_two || is_unary)) || (in_t4 && is_two);
    assign rout_field = in_t4 ? IR[RC_MSB:RC_LSB] : IR[RB_MSB:RB_LSB];
    assign rin_en     = (in_t4 && is_unary) || (in_t5 && is_short);
    assign alu_en     = (in_t3 && is_unary) || (in_t4 && is_two);

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .en     (rout_en),
        .field  (rout_field),
        .onehot (Rout)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .en     (rin_en),
        .field  (IR[RA_MSB:RA_LSB]),
        .onehot (Rin)
    );

    assign alu_op   = alu_en ? alu_onehot(opcode) : '0;
    assign Zin      = alu_en;
    assign PCout    = (state_reg == ST_T0);
    assign MARin    = (state_reg == ST_T0);
    assign IncPC    = (state_reg == ST_T0);
    assign Read     = (state_reg == ST_T1);
    assign MDRin    = (state_reg == ST_T1);
    assign MDRout   = (state_reg == ST_T2);
    assign IRin     = (state_reg == ST_T2);
    assign Yin      = in_t3 && is_two;
    assign Zlowout  = (in_t4 && is_unary) || (in_t5 && is_two);
    assign LOin     = in_t5 && is_long;
    assign Zhighout = in_t6 && is_long;
    assign HIin     = in_t6 && is_long;

    assign instr_done = (in_t3 && is_illegal && !HALT_ON_ILLEGAL)
                     || (in_t4 && is_unary)
                     || (in_t5 && is_short)
                     || (in_t6 && is_long);
    assign halted = (state_reg == ST_HALT);
    assign state  = state_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: each cycle's expected outputs are queued by the stimulus
// process and checked by an independent monitor on the falling edge.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] IR = 32'h0;
    logic [15:0] Rout, Rin;
    logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [12:0] alu_op;
    logic        instr_done, halted;
    logic [3:0]  state;

    always #5 clk = ~clk;

    control_sequencer #(.NUM_REGS(16), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .IR(IR),
        .Rout(Rout), .Rin(Rin), .PCout(PCout), .MARin(MARin), .IncPC(IncPC),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
        .LOin(LOin), .alu_op(alu_op), .instr_done(instr_done),
        .halted(halted), .state(state)
    );

    // Strobe vector bit order, LSB first
    localparam logic [12:0] S_PCOUT = 13'h0001, S_MARIN = 13'h0002, S_INCPC = 13'h0004;
    localparam logic [12:0] S_READ  = 13'h0008, S_MDRIN = 13'h0010, S_MDROUT = 13'h0020;
    localparam logic [12:0] S_IRIN  = 13'h0040, S_YIN   = 13'h0080, S_ZIN   = 13'h0100;
    localparam logic [12:0] S_ZLO   = 13'h0200, S_ZHI   = 13'h0400, S_HIIN  = 13'h0800;
    localparam logic [12:0] S_LOIN  = 13'h1000;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ro;
        logic [15:0] ri;
        logic [12:0] alu;
        logic [12:0] sb;
        logic        dn;
        logic        hl;
    } obs_t;

    obs_t  exp_q[$];
    string lbl_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e, a;
            string l;
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            a.st  = state;
            a.ro  = Rout;
            a.ri  = Rin;
            a.alu = alu_op;
            a.sb  = {LOin, HIin, Zhighout, Zlowout, Zin, Yin, IRin, MDRout,
                     MDRin, Read, IncPC, MARin, PCout};
            a.dn  = instr_done;
            a.hl  = halted;
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got st=%0d ro=%h ri=%h alu=%h sb=%h dn=%b hl=%b, want st=%0d ro=%h ri=%h alu=%h sb=%h dn=%b hl=%b",
                         l, a.st, a.ro, a.ri, a.alu, a.sb, a.dn, a.hl,
                         e.st, e.ro, e.ri, e.alu, e.sb, e.dn, e.hl);
            end else begin
                $display("ok   %s: st=%0d ro=%h ri=%h alu=%h sb=%h dn=%b hl=%b",
                         l, a.st, a.ro, a.ri, a.alu, a.sb, a.dn, a.hl);
            end
        end
    end

    task automatic cyc(input string l, input logic rst, input logic rn, input logic mr,
                       input logic [31:0] ir, input logic [3:0] st, input logic [15:0] ro,
                       input logic [15:0] ri, input logic [12:0] alu, input logic [12:0] sb,
                       input logic dn, input logic hl);
        obs_t e;
        e = '{st: st, ro: ro, ri: ri, alu: alu, sb: sb, dn: dn, hl: hl};
        reset = rst; run = rn; mem_ready = mr; IR = ir;
        exp_q.push_back(e);
        lbl_q.push_back(l);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string n);
        cyc({n, " T0"}, 0, 1, 1, 32'h0, 4'd1, 16'h0, 16'h0, 13'h0, S_PCOUT | S_MARIN | S_INCPC, 0, 0);
        cyc({n, " T1"}, 0, 1, 1, 32'h0, 4'd2, 16'h0, 16'h0, 13'h0, S_READ | S_MDRIN, 0, 0);
        cyc({n, " T2"}, 0, 1, 1, 32'h0, 4'd3, 16'h0, 16'h0, 13'h0, S_MDROUT | S_IRIN, 0, 0);
    endtask

    localparam logic [31:0] IR_ADD = 32'h1A1B8000;  // add R4,R3,R7
    localparam logic [31:0] IR_MUL = 32'h781B8000;  // mul R3,R7
    localparam logic [31:0] IR_NEG = 32'h8A180000;  // neg R4,R3
    localparam logic [31:0] IR_NOT = 32'h90000000;  // not R0,R0
    localparam logic [31:0] IR_SUB = 32'h20978000;  // sub R1,R2,R15
    localparam logic [31:0] IR_ILL = 32'hF8000000;  // opcode 31

    initial begin
        @(posedge clk);
        #1;
        cyc("reset idle",  1, 0, 1, 32'h0, 4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);
        cyc("idle no run", 0, 0, 1, 32'h0, 4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);
        cyc("idle run",    0, 1, 1, 32'h0, 4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);

        fetch("add");
        cyc("add T3", 0, 1, 1, IR_ADD, 4'd4, 16'h0008, 16'h0,    13'h0,    S_YIN, 0, 0);
        cyc("add T4", 0, 1, 1, IR_ADD, 4'd5, 16'h0080, 16'h0,    13'h0004, S_ZIN, 0, 0);
        cyc("add T5", 0, 1, 1, IR_ADD, 4'd6, 16'h0,    16'h0010, 13'h0,    S_ZLO, 1, 0);

        fetch("mul");
        cyc("mul T3", 0, 1, 1, IR_MUL, 4'd4, 16'h0008, 16'h0, 13'h0,    S_YIN, 0, 0);
        cyc("mul T4", 0, 1, 1, IR_MUL, 4'd5, 16'h0080, 16'h0, 13'h0010, S_ZIN, 0, 0);
        cyc("mul T5", 0, 1, 1, IR_MUL, 4'd6, 16'h0,    16'h0, 13'h0,    S_ZLO | S_LOIN, 0, 0);
        cyc("mul T6", 0, 1, 1, IR_MUL, 4'd7, 16'h0,    16'h0, 13'h0,    S_ZHI | S_HIIN, 1, 0);

        cyc("neg T0", 0, 1, 1, 32'h0, 4'd1, 16'h0, 16'h0, 13'h0, S_PCOUT | S_MARIN | S_INCPC, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("neg T1 wait%0d", i), 0, 1, 0, 32'h0, 4'd2, 16'h0, 16'h0, 13'h0, S_READ | S_MDRIN, 0, 0);
        cyc("neg T1 ready", 0, 1, 1, 32'h0, 4'd2, 16'h0, 16'h0, 13'h0, S_READ | S_MDRIN, 0, 0);
        cyc("neg T2", 0, 1, 1, 32'h0, 4'd3, 16'h0, 16'h0, 13'h0, S_MDROUT | S_IRIN, 0, 0);
        cyc("neg T3 run0", 0, 0, 1, IR_NEG, 4'd4, 16'h0008, 16'h0,    13'h0800, S_ZIN, 0, 0);
        cyc("neg T4 run0", 0, 0, 1, IR_NEG, 4'd5, 16'h0,    16'h0010, 13'h0,    S_ZLO, 1, 0);
        cyc("after neg idle", 0, 0, 1, 32'h0, 4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);
        cyc("idle run2",      0, 1, 1, 32'h0, 4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);

        fetch("not");
        cyc("not T3 R0", 0, 1, 1, IR_NOT, 4'd4, 16'h0001, 16'h0,    13'h1000, S_ZIN, 0, 0);
        cyc("not T4 R0", 0, 1, 1, IR_NOT, 4'd5, 16'h0,    16'h0001, 13'h0,    S_ZLO, 1, 0);

        fetch("sub");
        cyc("sub T3", 0, 1, 1, IR_SUB, 4'd4, 16'h0004, 16'h0,    13'h0,    S_YIN, 0, 0);
        cyc("sub T4", 0, 1, 1, IR_SUB, 4'd5, 16'h8000, 16'h0,    13'h0008, S_ZIN, 0, 0);
        cyc("sub T5", 0, 1, 1, IR_SUB, 4'd6, 16'h0,    16'h0002, 13'h0,    S_ZLO, 1, 0);

        fetch("add-rst");
        cyc("add-rst T3", 0, 1, 1, IR_ADD, 4'd4, 16'h0008, 16'h0, 13'h0,    S_YIN, 0, 0);
        cyc("add-rst T4", 1, 1, 1, IR_ADD, 4'd5, 16'h0080, 16'h0, 13'h0004, S_ZIN, 0, 0);
        cyc("post-rst idle",  0, 0, 1, IR_ADD, 4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);
        cyc("post-rst idle2", 0, 1, 1, IR_ADD, 4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);

        fetch("ill");
        cyc("ill T3", 0, 1, 1, IR_ILL, 4'd4, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);
        for (int i = 0; i < 21; i++)
            cyc($sformatf("halt %0d", i), 0, 1, 1, IR_ILL, 4'd8, 16'h0, 16'h0, 13'h0, 13'h0, 0, 1);
        cyc("halt reset", 1, 1, 1, IR_ILL, 4'd8, 16'h0, 16'h0, 13'h0, 13'h0, 0, 1);
        cyc("halt->idle", 0, 0, 1, 32'h0,  4'd0, 16'h0, 16'h0, 13'h0, 13'h0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
